decode_issue: RTL and testbench
===============================

Name: decode_issue

Overview:
- Instruction decode/issue stage sitting directly upstream of the register file.
- Splits a 32-bit MIPS-style instruction into the RF read addresses (scr1/scr2), the destination (dest) and its write-enable, plus a sign- or zero-extended immediate.
- Holds a 32-entry scoreboard of pending register writes and stalls issue on RAW hazards until the matching writeback returns.
- Output is one registered pipeline slot with a valid/ready handshake toward execute.

Parameters:
- NREGS, 32, number of architectural registers; scoreboard width. Fixed at 32 because the register address is 5 bits.
- IMM_W, 32, width of the extended immediate output.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept in_instr this cycle
- in_instr  input  32  instruction: op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm[15:0]
- out_valid  output  1  decoded slot holds a valid instruction
- out_ready  input  1  downstream consumes the slot this cycle
- out_scr1  output  5  RF read address 1 (rs)
- out_scr2  output  5  RF read address 2 (rt)
- out_dest  output  5  RF destination address
- out_wr_en  output  1  instruction writes out_dest
- out_imm  output  IMM_W  extended immediate
- out_opcode  output  6  op field
- out_funct  output  6  funct field
- wb_valid  input  1  writeback of wb_dest occurs this cycle
- wb_dest  input  5  register being written back
- busy_vec  output  32  current scoreboard, bit n = write to register n pending

Behaviour:
- Reset: out_valid=0; out_scr1, out_scr2, out_dest, out_opcode, out_funct = 0; out_wr_en=0; out_imm=0; busy_vec=0. Reset wins over every other event in the same cycle.
- Decode, applied to in_instr:
  - op 0x00 (R-type): dest=rd, wr_en=1, uses rs and rt.
  - op 0x08–0x0E (I-type ALU): dest=rt, wr_en=1, uses rs.
  - op 0x0F (LUI): dest=rt, wr_en=1, uses no sources.
  - op 0x23 (LW): dest=rt, wr_en=1, uses rs.
  - op 0x2B (SW), 0x04 (BEQ), 0x05 (BNE): wr_en=0, uses rs and rt.
  - op 0x02 (J): wr_en=0, no sources.
  - op 0x03 (JAL): dest=31, wr_en=1, no sources.
  - Any other op: wr_en=0, no sources; passed through unchanged.
- If dest==0, out_wr_en is forced to 0. Register 0 is never marked busy.
- out_scr1/out_scr2 always carry the raw rs/rt fields, whether or not they are used.
- out_imm: zero-extended imm[15:0] for op 0x0C, 0x0D, 0x0E; sign-extended for all other ops.
- Hazard: asserted when a used source register has its busy bit set, evaluated against the registered busy_vec. A same-cycle wb_valid clear does NOT bypass the hazard; issue happens the following cycle.
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready).
  - Issue = in_valid && in_ready.
  - On issue, the output slot loads the decoded fields and out_valid=1.
  - When out_ready && out_valid without an issue, out_valid goes to 0.
  - Output fields hold their value while out_valid && !out_ready.
- Latency: one cycle from issue to out_valid. Back-to-back issue at one instruction per cycle when there are no hazards.
- Scoreboard:
  - On issue with wr_en=1, set busy[dest].
  - When wb_valid && wb_dest!=0, clear busy[wb_dest].
  - If a set and a clear hit the same register in the same cycle, the set wins and the bit stays 1.
  - A clear of a register that is not busy is ignored.
- A WAW re-issue to an already-busy dest is allowed. The bit stays set and the first matching writeback clears it.
- Reset while out_valid=1 or with busy bits set drops the slot and clears the scoreboard on the next edge.

Optional Feature:
- Macro DECODE_ISSUE_PERF_CNT_EN.
- When defined: adds output stall_cnt (32 bits, reset 0). It increments by 1 on every cycle with in_valid && hazard, counts only hazard stalls (not backpressure), and saturates at 0xFFFFFFFF.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Reset with in_valid=1 → out_valid=0, busy_vec=0, all outputs 0; one cycle after reset deasserts, 0x00A41020 (add $2,$5,$4) issues → out_scr1=5, out_scr2=4, out_dest=2, out_wr_en=1, busy_vec=0x00000004.
- Send 0x00A41020 followed immediately by 0x00430820 (add $1,$2,$3) → second instruction holds with in_ready=0; wb_valid=1, wb_dest=2 → busy bit 2 clears, second instruction issues the following cycle with out_dest=1.
- 0x3402FFFF (ori $2,$0,0xFFFF) → out_imm=0x0000FFFF; 0x2002FFFF (addi) → out_imm=0xFFFFFFFF; 0xAC020004 (sw) → out_wr_en=0, busy_vec unchanged.
- 0x00001020-style instruction with rd=0 → out_wr_en=0 and busy bit 0 never sets; JAL 0x0C000000 → out_dest=31, busy_vec bit 31 set.
- Hold out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and outputs stable; release → slot drains, or reloads the same cycle if in_valid=1.
- Same-cycle issue writing $7 while wb_valid clears $7 → busy bit 7 remains 1. With DECODE_ISSUE_PERF_CNT_EN defined, a 4-cycle RAW stall → stall_cnt=4.

Source files
------------

// File: rtl/decode_issue_if.sv
// -----------------------------------------------------------------------------
// decode_issue_if
// Groups the bus between the fetch side, the decode/issue stage, execute and
// writeback into one interface.
//   in_valid/in_ready/in_instr : instruction handshake from upstream
//   out_valid/out_ready        : registered pipeline slot toward execute
//   out_scr1/out_scr2/out_dest : register file read/write addresses
//   out_wr_en/out_imm          : destination write enable, extended immediate
//   out_opcode/out_funct       : raw op and funct fields
//   wb_valid/wb_dest           : writeback that releases a pending register
//   busy_vec                   : scoreboard of pending register writes
// Modports: master = the environment around the stage, slave = the stage.
// -----------------------------------------------------------------------------
interface decode_issue_if #(
   parameter int IMM_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       out_scr1;
   logic [4:0]       out_scr2;
   logic [4:0]       out_dest;
   logic             out_wr_en;
   logic [IMM_W-1:0] out_imm;
   logic [5:0]       out_opcode;
   logic [5:0]       out_funct;
   logic             wb_valid;
   logic [4:0]       wb_dest;
   logic [31:0]      busy_vec;

   modport master (
      output in_valid, in_instr, out_ready, wb_valid, wb_dest,
      input  in_ready, out_valid, out_scr1, out_scr2, out_dest, out_wr_en,
             out_imm, out_opcode, out_funct, busy_vec
   );

   modport slave (
      input  in_valid, in_instr, out_ready, wb_valid, wb_dest,
      output in_ready, out_valid, out_scr1, out_scr2, out_dest, out_wr_en,
             out_imm, out_opcode, out_funct, busy_vec
   );
endinterface

// File: rtl/decode_issue.sv
// -----------------------------------------------------------------------------
// decode_issue
// Decode/issue stage in front of the register file. Splits a MIPS-style
// instruction into read addresses, destination and extended immediate, keeps a
// scoreboard of pending register writes and stalls issue on RAW hazards until
// the matching writeback arrives. Output is a single registered slot with a
// valid/ready handshake toward execute.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous active-high reset
//   bus       : decode_issue_if.slave (instruction, output slot, writeback,
//               scoreboard)
//   stall_cnt : hazard stall counter, only when DECODE_ISSUE_PERF_CNT_EN is
//               defined
// Optional feature macro: DECODE_ISSUE_PERF_CNT_EN
// -----------------------------------------------------------------------------
module decode_issue #(
   parameter int NREGS = 32,
   parameter int IMM_W = 32
) (
   input  logic          clk,
   input  logic          reset,
   decode_issue_if.slave bus
`ifdef DECODE_ISSUE_PERF_CNT_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);

   // Instruction fields
   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [15:0] imm16;

   assign op    = bus.in_instr[31:26];
   assign rs    = bus.in_instr[25:21];
   assign rt    = bus.in_instr[20:16];
   assign rd    = bus.in_instr[15:11];
   assign funct = bus.in_instr[5:0];
   assign imm16 = bus.in_instr[15:0];

   // Decoded controls
   logic             dec_wr;
   logic             dec_wr_en;
   logic [4:0]       dec_dest;
   logic             use_rs;
   logic             use_rt;
   logic             zero_ext;
   logic [IMM_W-1:0] dec_imm;

   always_comb begin
      dec_wr   = 1'b0;
      dec_dest = 5'd0;
      use_rs   = 1'b0;
      use_rt   = 1'b0;
      case (op)
         6'h00: begin
            dec_dest = rd;
            dec_wr   = 1'b1;
            use_rs   = 1'b1;
            use_rt   = 1'b1;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23: begin
            dec_dest = rt;
            dec_wr   = 1'b1;
            use_rs   = 1'b1;
         end
         6'h0F: begin
            dec_dest = rt;
            dec_wr   = 1'b1;
         end
         6'h2B, 6'h04, 6'h05: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
         end
         6'h03: begin
            dec_dest = 5'd31;
            dec_wr   = 1'b1;
         end
         default: begin
            dec_wr = 1'b0;
         end
      endcase
   end

   // Writes to register 0 are discarded, so never claim it in the scoreboard
   assign dec_wr_en = dec_wr && (dec_dest != 5'd0);

   // Logical immediates (andi/ori/xori) zero-extend, everything else sign-extends
   assign zero_ext = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
   assign dec_imm  = zero_ext ? {{(IMM_W-16){1'b0}}, imm16}
                              : {{(IMM_W-16){imm16[15]}}, imm16};

   // Scoreboard and handshake
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic             hazard;
   logic             in_ready;
   logic             issue;
   logic             out_valid_q;
   logic             out_valid_d;

   // Hazard looks only at the registered scoreboard; a writeback in the same
   // cycle releases the consumer one cycle later, keeping this path short.
   assign hazard   = (use_rs && busy_q[rs]) || (use_rt && busy_q[rt]);
   assign in_ready = !hazard && (!out_valid_q || bus.out_ready);
   assign issue    = bus.in_valid && in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_sb
         if (gi == 0) begin : g_zero
            assign busy_d[gi] = 1'b0;
         end else begin : g_bit
            logic set_hit;
            logic clr_hit;
            assign set_hit = issue && dec_wr_en && (dec_dest == 5'(gi));
            assign clr_hit = bus.wb_valid && (bus.wb_dest == 5'(gi));
            // A set in the same cycle as a clear wins: the new producer is
            // still outstanding.
            assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
         end
      end
   endgenerate

   always_comb begin
      out_valid_d = out_valid_q;
      if (issue) begin
         out_valid_d = 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output slot
   logic [4:0]       scr1_q;
   logic [4:0]       scr2_q;
   logic [4:0]       dest_q;
   logic             wr_en_q;
   logic [IMM_W-1:0] imm_q;
   logic [5:0]       opcode_q;
   logic [5:0]       funct_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         busy_q      <= '0;
         scr1_q      <= 5'd0;
         scr2_q      <= 5'd0;
         dest_q      <= 5'd0;
         wr_en_q     <= 1'b0;
         imm_q       <= '0;
         opcode_q    <= 6'd0;
         funct_q     <= 6'd0;
      end else begin
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         if (issue) begin
            scr1_q   <= rs;
            scr2_q   <= rt;
            dest_q   <= dec_dest;
            wr_en_q  <= dec_wr_en;
            imm_q    <= dec_imm;
            opcode_q <= op;
            funct_q  <= funct;
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_scr1   = scr1_q;
   assign bus.out_scr2   = scr2_q;
   assign bus.out_dest   = dest_q;
   assign bus.out_wr_en  = wr_en_q;
   assign bus.out_imm    = imm_q;
   assign bus.out_opcode = opcode_q;
   assign bus.out_funct  = funct_q;
   assign bus.busy_vec   = 32'(busy_q);

`ifdef DECODE_ISSUE_PERF_CNT_EN
   // Counts only hazard stalls; backpressure cycles are not included.
   logic [31:0] stall_cnt_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else if (bus.in_valid && hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_issue.sv
// -----------------------------------------------------------------------------
// tb_decode_issue
// Directed bench for decode_issue. Stimulus pushes the hand-computed expected
// slot contents into a queue at issue time; a monitor pops and compares each
// time the DUT hands a slot to execute. Scoreboard, handshake and reset
// behaviour are checked inline by the stimulus process.
// Optional feature macro: DECODE_ISSUE_PERF_CNT_EN (adds stall_cnt checks).
// -----------------------------------------------------------------------------
module tb_decode_issue;

   logic clk;
   logic reset;

   decode_issue_if #(.IMM_W(32)) bus ();

`ifdef DECODE_ISSUE_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] stall_base;
`endif

   decode_issue #(.NREGS(32), .IMM_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus)
`ifdef DECODE_ISSUE_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  s1;
      logic [4:0]  s2;
      logic [4:0]  d;
      logic        wr;
      logic [31:0] imm;
      bit          chk_d;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Monitor: compare every slot consumed by execute against the queue head
   always @(negedge clk) begin
      if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_slot: got instr op 0x%02h, expected none", bus.out_opcode);
         end else begin
            exp_t e;
            logic [31:0] ei;
            e  = exp_q.pop_front();
            ei = e.instr;
            $display("slot instr 0x%08h", e.instr);
            check("out_scr1",   32'(bus.out_scr1),   32'(e.s1));
            check("out_scr2",   32'(bus.out_scr2),   32'(e.s2));
            check("out_wr_en",  32'(bus.out_wr_en),  32'(e.wr));
            check("out_imm",    bus.out_imm,         e.imm);
            check("out_opcode", 32'(bus.out_opcode), 32'(ei[31:26]));
            check("out_funct",  32'(bus.out_funct),  32'(ei[5:0]));
            if (e.chk_d) check("out_dest", 32'(bus.out_dest), 32'(e.d));
         end
      end
   end

   // Offer one instruction, wait (bounded) for in_ready, return just after the
   // issuing edge with in_valid dropped.
   task automatic issue(input logic [31:0] instr, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic wr, input logic [31:0] imm,
                        input bit chk_d, input bit push);
      exp_t e;
      int   n;
      e.instr = instr; e.s1 = s1; e.s2 = s2; e.d = d; e.wr = wr; e.imm = imm; e.chk_d = chk_d;
      if (push) exp_q.push_back(e);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      #1;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL issue_timeout: got in_ready 0, expected 1 for instr 0x%08h", instr);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wb(input logic [4:0] r);
      bus.wb_valid = 1'b1;
      bus.wb_dest  = r;
      @(posedge clk); #1;
      bus.wb_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h00A41020;
      bus.out_ready = 1'b1;
      bus.wb_valid  = 1'b0;
      bus.wb_dest   = 5'd0;

      // Reset with in_valid held high
      idle(2);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy_vec",  bus.busy_vec,       32'd0);
      check("rst_out_dest",  32'(bus.out_dest),  32'd0);
      check("rst_out_wr_en", 32'(bus.out_wr_en), 32'd0);
      check("rst_out_imm",   bus.out_imm,        32'd0);
      check("rst_out_scr1",  32'(bus.out_scr1),  32'd0);
`ifdef DECODE_ISSUE_PERF_CNT_EN
      check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
      bus.in_valid = 1'b0;
      reset        = 1'b0;
      idle(1);

      // add $2,$5,$4
      issue(32'h00A41020, 5'd5, 5'd4, 5'd2, 1'b1, 32'h00001020, 1'b1, 1'b1);
      check("busy_after_add", bus.busy_vec, 32'h00000004);

      // add $1,$2,$3 stalls on $2 until its writeback
      exp_q.push_back('{32'h00430820, 5'd2, 5'd3, 5'd1, 1'b1, 32'h00000820, 1'b1});
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h00430820;
      #1;
      check("raw_in_ready_0", 32'(bus.in_ready), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         check("raw_in_ready_hold", 32'(bus.in_ready), 32'd0);
      end
      bus.wb_valid = 1'b1;
      bus.wb_dest  = 5'd2;
      #1;
      check("raw_no_bypass", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      bus.wb_valid = 1'b0;
      check("raw_busy_cleared", bus.busy_vec, 32'h00000000);
      check("raw_in_ready_1",   32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("busy_after_add1", bus.busy_vec, 32'h00000002);

      // Immediate extension and store
      issue(32'h3402FFFF, 5'd0, 5'd2, 5'd2, 1'b1, 32'h0000FFFF, 1'b1, 1'b1);
      issue(32'h2002FFFF, 5'd0, 5'd2, 5'd2, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
      check("busy_waw", bus.busy_vec, 32'h00000006);
      wb(5'd1);
      wb(5'd2);
      check("busy_waw_single_clear", bus.busy_vec, 32'h00000000);
      issue(32'hAC020004, 5'd0, 5'd2, 5'd0, 1'b0, 32'h00000004, 1'b0, 1'b1);
      check("busy_after_sw", bus.busy_vec, 32'h00000000);

      // rd = 0 and JAL
      issue(32'h00000020, 5'd0, 5'd0, 5'd0, 1'b0, 32'h00000020, 1'b1, 1'b1);
      check("busy_after_rd0", bus.busy_vec, 32'h00000000);
      issue(32'h0C000000, 5'd0, 5'd0, 5'd31, 1'b1, 32'h00000000, 1'b1, 1'b1);
      check("busy_after_jal", bus.busy_vec, 32'h80000000);
      wb(5'd31);
      idle(1);

      // Backpressure: hold slot for 3 cycles, then reload in the release cycle
      bus.out_ready = 1'b0;
      issue(32'h20030007, 5'd0, 5'd3, 5'd3, 1'b1, 32'h00000007, 1'b1, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h20040008;
      #1;
      repeat (3) begin
         check("bp_in_ready",  32'(bus.in_ready),  32'd0);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_out_dest",  32'(bus.out_dest),  32'd3);
         check("bp_out_imm",   bus.out_imm,        32'h00000007);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      issue(32'h20040008, 5'd0, 5'd4, 5'd4, 1'b1, 32'h00000008, 1'b1, 1'b1);
      check("bp_reload_valid", 32'(bus.out_valid), 32'd1);
      check("busy_after_bp",   bus.busy_vec, 32'h00000018);
      wb(5'd3);
      wb(5'd4);

      // Same-cycle set and clear of $7: set wins
      issue(32'h20070001, 5'd0, 5'd7, 5'd7, 1'b1, 32'h00000001, 1'b1, 1'b1);
      bus.wb_valid = 1'b1;
      bus.wb_dest  = 5'd7;
      issue(32'h20070002, 5'd0, 5'd7, 5'd7, 1'b1, 32'h00000002, 1'b1, 1'b1);
      bus.wb_valid = 1'b0;
      check("set_wins_bit7", bus.busy_vec, 32'h00000080);
      wb(5'd9);
      check("clear_not_busy", bus.busy_vec, 32'h00000080);
      wb(5'd0);
      check("clear_reg0", bus.busy_vec, 32'h00000080);
      wb(5'd7);
      check("clear_bit7", bus.busy_vec, 32'h00000000);

      // Four-cycle RAW stall on $5
      issue(32'h20050003, 5'd0, 5'd5, 5'd5, 1'b1, 32'h00000003, 1'b1, 1'b1);
      exp_q.push_back('{32'h00A03020, 5'd5, 5'd0, 5'd6, 1'b1, 32'h00003020, 1'b1});
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h00A03020;
`ifdef DECODE_ISSUE_PERF_CNT_EN
      stall_base = stall_cnt;
`endif
      idle(3);
      bus.wb_valid = 1'b1;
      bus.wb_dest  = 5'd5;
      @(posedge clk); #1;
      bus.wb_valid = 1'b0;
      check("stall_in_ready_1", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("busy_after_stall", bus.busy_vec, 32'h00000040);
`ifdef DECODE_ISSUE_PERF_CNT_EN
      check("stall_cnt_delta", stall_cnt - stall_base, 32'd4);
`endif
      wb(5'd6);
      idle(2);

      // Reset with a held slot and a busy bit drops both
      bus.out_ready = 1'b0;
      issue(32'h20080000, 5'd0, 5'd8, 5'd8, 1'b1, 32'h00000000, 1'b1, 1'b0);
      check("pre_rst_busy", bus.busy_vec, 32'h00000100);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst2_busy_vec",  bus.busy_vec,       32'd0);
      check("rst2_out_dest",  32'(bus.out_dest),  32'd0);
      bus.out_ready = 1'b1;
      idle(3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
